// File: rtl/gtp_loader_pkg.sv
// Shared types and constants for the Galaksija tape-block loader.
// GTP_HEADER_EN adds the HDR state used to skip the 5-byte GTP block header.
package gtp_loader_pkg;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         GTP_HDR_LEN  = 5;
  localparam logic [7:0] GTP_TYPE_STD = 8'h00;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_ST_LO,
    S_ST_HI,
    S_EN_LO,
    S_EN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
`ifdef GTP_HEADER_EN
    , S_HDR
`endif
  } state_t;

`ifdef GTP_HEADER_EN
  localparam state_t START_STATE = S_HDR;
`else
  localparam state_t START_STATE = S_SYNC;
`endif

  function automatic logic is_loading(state_t s);
    return !(s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

  // Bytes from start-address low through the checksum feed the running sum.
  function automatic logic in_sum_span(state_t s);
    return s inside {S_ST_LO, S_ST_HI, S_EN_LO, S_EN_HI, S_DATA, S_CSUM};
  endfunction

endpackage

// File: rtl/gtp_loader_if.sv
// Bundles the hps_io download stream and the Galaksija RAM write port.
// ioctl_wr is a one-cycle valid strobe, sent only while ioctl_wait is low; ram_we is
// valid and holds ram_addr/ram_dout stable until ram_ack (ready) is high on a rising edge.
interface gtp_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_ack;

  modport master (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ram_ack,
    output ioctl_wait, ram_we, ram_addr, ram_dout
  );

  modport slave (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ram_ack,
    input  ioctl_wait, ram_we, ram_addr, ram_dout
  );
endinterface

// File: rtl/gtp_loader_fifo.sv
// Synchronous byte FIFO between the ioctl strobe and the block parser.
// A flush coinciding with a push keeps that byte as the new head.
module gtp_loader_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         almost_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= (AW+1)'(DEPTH - 1));
  assign do_push     = push && (flush || !full);
  assign do_pop      = pop && !empty && !flush;
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= do_push ? (AW+1)'(1) : '0;
      end else begin
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/gtp_loader.sv
// Parses a Galaksija tape block from the hps_io stream and writes it to RAM.
// Build option: GTP_HEADER_EN consumes a 5-byte GTP block header before the sync byte.
module gtp_loader
  import gtp_loader_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] CSUM_OK    = 8'hFF
) (
  input  logic         clk_sys,
  input  logic         reset_in,
  gtp_loader_if.master bus,
  output logic         cpu_busreq,
  output logic         load_done,
  output logic         load_err,
  output state_t       state_dbg
);
  state_t      state, state_n;
  logic        dl_q, restart, truncated, overflow, pop;
  logic        fifo_empty, fifo_full, fifo_af;
  logic [7:0]  byte_in, sum_next, dout_q;
  logic [15:0] addr_q, end_q;
  logic [7:0]  sum_q;
`ifdef GTP_HEADER_EN
  logic [2:0]  hdr_cnt;
  logic        in_hdr;
  assign in_hdr = (state == S_HDR);
`else
  logic        in_hdr;
  assign in_hdr = 1'b0;
`endif

  gtp_loader_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk(clk_sys), .rst_n(reset_in), .push(bus.ioctl_wr), .pop(pop), .flush(restart),
    .din(bus.ioctl_dout), .dout(byte_in), .full(fifo_full), .empty(fifo_empty),
    .almost_full(fifo_af)
  );

  // A write to file offset 0 outside the sync/header phase means hps_io restarted the file.
  assign restart   = (bus.ioctl_download && !dl_q) ||
                     (bus.ioctl_wr && bus.ioctl_addr == '0 && state != S_SYNC && !in_hdr);
  assign truncated = is_loading(state) && state != S_WRITE && fifo_empty &&
                     !bus.ioctl_download && !bus.ioctl_wr;
  assign overflow  = bus.ioctl_wr && fifo_full && is_loading(state);
  assign sum_next  = sum_q + byte_in;

  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) state <= S_IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
`ifdef GTP_HEADER_EN
      S_HDR: if (!fifo_empty) begin
        if (hdr_cnt == 3'd0 && byte_in != GTP_TYPE_STD) state_n = S_ERR;
        else if (hdr_cnt == 3'(GTP_HDR_LEN - 1))       state_n = S_SYNC;
      end
`endif
      S_SYNC:  if (!fifo_empty) state_n = (byte_in == SYNC_BYTE) ? S_ST_LO : S_ERR;
      S_ST_LO: if (!fifo_empty) state_n = S_ST_HI;
      S_ST_HI: if (!fifo_empty) state_n = S_EN_LO;
      S_EN_LO: if (!fifo_empty) state_n = S_EN_HI;
      // end is exclusive and never wraps, so end==0 with any start is rejected here too.
      S_EN_HI: if (!fifo_empty) state_n = ({byte_in, end_q[7:0]} <= addr_q) ? S_ERR : S_DATA;
      S_DATA:  if (!fifo_empty) state_n = S_WRITE;
      S_WRITE: if (bus.ram_ack) state_n = (addr_q + 16'd1 == end_q) ? S_CSUM : S_DATA;
      S_CSUM:  if (!fifo_empty) state_n = (sum_next != CSUM_OK) ? S_ERR : S_DONE;
      default: state_n = state;
    endcase
    if (truncated || overflow) state_n = S_ERR;
    if (restart)               state_n = START_STATE;
  end

  always_comb begin
    pop        = !fifo_empty && (state != S_WRITE);
    bus.ram_we = (state == S_WRITE);
  end

  assign bus.ram_addr   = addr_q;
  assign bus.ram_dout   = dout_q;
  assign bus.ioctl_wait = fifo_af;
  assign state_dbg      = state;

  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) begin
      addr_q <= '0;
      end_q  <= '0;
      sum_q  <= '0;
      dout_q <= '0;
    end else if (restart) begin
      sum_q <= '0;
    end else begin
      if (pop) begin
        unique case (state)
          S_ST_LO: addr_q[7:0]  <= byte_in;
          S_ST_HI: addr_q[15:8] <= byte_in;
          S_EN_LO: end_q[7:0]   <= byte_in;
          S_EN_HI: end_q[15:8]  <= byte_in;
          S_DATA:  dout_q       <= byte_in;
          default: ;
        endcase
        if (in_sum_span(state)) sum_q <= sum_next;
      end
      if (state == S_WRITE && bus.ram_ack) addr_q <= addr_q + 16'd1;
    end
  end

`ifdef GTP_HEADER_EN
  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in)                     hdr_cnt <= '0;
    else if (restart)                  hdr_cnt <= '0;
    else if (pop && state == S_HDR)    hdr_cnt <= hdr_cnt + 3'd1;
  end
`endif

  always_ff @(posedge clk_sys or negedge reset_in) begin
    if (!reset_in) begin
      dl_q       <= 1'b0;
      cpu_busreq <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (restart) begin
        cpu_busreq <= 1'b1;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
      end else begin
        if (state_n == S_DONE) load_done <= 1'b1;
        if (state_n == S_ERR)  load_err  <= 1'b1;
        if (!is_loading(state) && fifo_empty && !bus.ioctl_download) cpu_busreq <= 1'b0;
      end
    end
  end
endmodule
